// File: rtl/alu_scheduler.sv
// Round-robin front end for a single shared registered ALU: accepts one command at a time,
// holds the ALU inputs for ALU_LATENCY edges, captures the result and returns it tagged.
module alu_scheduler #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_b0,
  input  logic [2:0] req_s0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b1,
  input  logic [2:0] req_s1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_s,
  input  logic [7:0] alu_o,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam logic [2:0] LAT = 3'(ALU_LATENCY);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
  } cmd_t;

  state_t     state;
  logic [2:0] cnt;
  logic       last_grant;
  logic       grant;
  cmd_t [1:0] cmd;

  assign cmd[0] = {req_a0, req_b0, req_s0};
  assign cmd[1] = {req_a1, req_b1, req_s1};

  // On a tie the requester not served last wins; otherwise whichever one is valid.
  assign grant = (&req_valid) ? ~last_grant : req_valid[1];

  always_comb begin
    req_ready = '0;
    if (reset_n && state == IDLE)
      req_ready = req_valid & (grant ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: if (|req_ready) begin
          last_grant <= grant;
          rsp_id     <= grant;
          alu_a      <= cmd[grant].a;
          alu_b      <= cmd[grant].b;
          alu_s      <= cmd[grant].s;
          cnt        <= '0;
          busy       <= 1'b1;
          state      <= EXEC;
        end
        EXEC: begin
          cnt <= cnt + 3'd1;
          // alu_o is only trusted on this edge; inputs have been stable for LAT edges.
          if (cnt == LAT) begin
            rsp_data  <= alu_o;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + 8'd1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: vector table, directed corner sequences and a randomized run
// against a transaction-level reference model. A second instance covers ALU_LATENCY=3.
module tb_alu_scheduler;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] req_valid, req_ready;
  logic [3:0] req_a0, req_b0, req_a1, req_b1, alu_a, alu_b;
  logic [2:0] req_s0, req_s1, alu_s;
  logic [7:0] alu_o, rsp_data, op_count;
  logic       rsp_valid, rsp_ready, rsp_id, busy;

  logic [1:0] l3_req_valid, l3_req_ready;
  logic [3:0] l3_req_a0, l3_req_b0, l3_req_a1, l3_req_b1, l3_alu_a, l3_alu_b;
  logic [2:0] l3_req_s0, l3_req_s1, l3_alu_s;
  logic [7:0] l3_alu_o, l3_rsp_data, l3_op_count, l3_p1, l3_p2;
  logic       l3_rsp_valid, l3_rsp_ready, l3_rsp_id, l3_busy;

  alu_scheduler #(.ALU_LATENCY(1)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_s0(req_s0),
    .req_a1(req_a1), .req_b1(req_b1), .req_s1(req_s1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
  );

  alu_scheduler #(.ALU_LATENCY(3)) dut_l3 (
    .clock(clock), .reset_n(reset_n), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_a0(l3_req_a0), .req_b0(l3_req_b0), .req_s0(l3_req_s0),
    .req_a1(l3_req_a1), .req_b1(l3_req_b1), .req_s1(l3_req_s1),
    .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_s(l3_alu_s), .alu_o(l3_alu_o),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_id(l3_rsp_id),
    .rsp_data(l3_rsp_data), .busy(l3_busy), .op_count(l3_op_count)
  );

  // Bench ALUs: plain adders ignoring the select, latency 1 and 3.
  always @(posedge clock) alu_o <= {4'b0, alu_a} + {4'b0, alu_b};
  always @(posedge clock) begin
    l3_p1    <= {4'b0, l3_alu_a} + {4'b0, l3_alu_b};
    l3_p2    <= l3_p1;
    l3_alu_o <= l3_p2;
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_cnt = '0;
  endtask

  // One isolated command with rsp_ready high: accept in cycle 0, response in cycle 3.
  task automatic run_one(input bit id, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] s, input logic [7:0] ed);
    step;
    rsp_ready = 1'b1;
    if (id) begin req_a1 = a; req_b1 = b; req_s1 = s; req_valid = 2'b10; end
    else    begin req_a0 = a; req_b0 = b; req_s0 = s; req_valid = 2'b01; end
    smp;
    chk("vec_ready", req_ready, id ? 2'b10 : 2'b01);
    chk("vec_idle_busy", busy, 0);
    step; req_valid = '0; smp;
    chk("vec_alu_a", alu_a, a);
    chk("vec_alu_b", alu_b, b);
    chk("vec_alu_s_c1", alu_s, s);
    chk("vec_no_rsp_c1", rsp_valid, 0);
    step; smp;
    chk("vec_alu_s_c2", alu_s, s);
    chk("vec_no_rsp_c2", rsp_valid, 0);
    step; smp;
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_data", rsp_data, ed);
    chk("vec_rsp_id", rsp_id, id);
    exp_cnt++;
    step; smp;
    chk("vec_op_count", op_count, exp_cnt);
    chk("vec_busy_after", busy, 0);
  endtask

  typedef struct {
    bit         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[6];

  // reference-model state for the random run
  bit         m_pend, m_lastg, m_w, m_erv;
  int         m_acc_t;
  logic [7:0] m_data;
  logic [3:0] m_a, m_b;
  logic [2:0] m_s;
  logic [1:0] m_er, m_acc;
  int n, t;
  bit chk_next, done;

  initial begin
    vt[0] = '{1'b0, 4'd9,  4'd13, 3'd0, 8'h16};
    vt[1] = '{1'b1, 4'd2,  4'd9,  3'd3, 8'h0B};
    vt[2] = '{1'b0, 4'd15, 4'd15, 3'd7, 8'h1E};
    vt[3] = '{1'b1, 4'd0,  4'd0,  3'd5, 8'h00};
    vt[4] = '{1'b0, 4'd8,  4'd4,  3'd2, 8'h0C};
    vt[5] = '{1'b1, 4'd12, 4'd10, 3'd6, 8'h16};

    req_a0 = '0; req_b0 = '0; req_s0 = '0; req_a1 = '0; req_b1 = '0; req_s1 = '0;
    l3_req_valid = '0; l3_rsp_ready = 1'b0;
    l3_req_a0 = '0; l3_req_b0 = '0; l3_req_s0 = '0;
    l3_req_a1 = '0; l3_req_b1 = '0; l3_req_s1 = '0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_s", alu_s, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    do_reset;

    for (int i = 0; i < 6; i++) run_one(vt[i].id, vt[i].a, vt[i].b, vt[i].s, vt[i].exp);

    // Tie after reset: grants 0,1,0,1 each four cycles apart.
    do_reset;
    begin
      int na, nr, last_t;
      na = 0; nr = 0; last_t = 0;
      step;
      req_a0 = 4'd8; req_b0 = 4'd4; req_s0 = 3'd0;
      req_a1 = 4'd12; req_b1 = 4'd10; req_s1 = 3'd1;
      req_valid = 2'b11; rsp_ready = 1'b1;
      for (int c = 0; c < 40 && nr < 4; c++) begin
        smp;
        if (req_ready != 0) begin
          chk("tie_grant", req_ready, (na % 2) ? 2'b10 : 2'b01);
          if (na > 0) chk("tie_spacing", c - last_t, 4);
          last_t = c;
          na++;
        end
        if (rsp_valid) begin
          chk("tie_rsp_id", rsp_id, nr % 2);
          chk("tie_rsp_data", rsp_data, (nr % 2) ? 8'h16 : 8'h0C);
          nr++;
        end
        if (nr < 4) step;
      end
      if (nr < 4) chk("tie_timeout", nr, 4);
      step;
      req_valid = '0;
    end

    // Backpressure on a requester-1 response while requester 0 waits.
    step;
    rsp_ready = 1'b0;
    req_a1 = 4'd2; req_b1 = 4'd9; req_s1 = 3'b011; req_valid = 2'b10;
    smp; chk("bp_accept1", req_ready, 2'b10);
    step; req_valid = 2'b01; req_a0 = 4'd1; req_b0 = 4'd3; req_s0 = 3'd0;
    smp; chk("bp_exec_ready", req_ready, 0);
    step; smp; chk("bp_alu_s", alu_s, 3'b011);
    for (int k = 0; k < 10; k++) begin
      step; smp;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 8'h0B);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_req_ready", req_ready, 0);
    end
    step; rsp_ready = 1'b1; smp; chk("bp_handshake", rsp_valid, 1);
    step; smp; chk("bp_next_accept0", req_ready, 2'b01);
    step; req_valid = '0; smp;
    step; smp;
    step; smp;
    chk("bp_r0_valid", rsp_valid, 1);
    chk("bp_r0_data", rsp_data, 8'h04);
    chk("bp_r0_id", rsp_id, 0);
    step; smp; chk("bp_idle", busy, 0);

    // Asynchronous reset in cycle 1 of an operation.
    step;
    req_a0 = 4'd3; req_b0 = 4'd4; req_valid = 2'b01; rsp_ready = 1'b1;
    smp; chk("mid_accept", req_ready, 2'b01);
    step;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_req_ready", req_ready, 0);
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_b", alu_b, 0);
    chk("mid_alu_s", alu_s, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_id", rsp_id, 0);
    chk("mid_rsp_data", rsp_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_op_count", op_count, 0);
    req_valid = '0;
    @(negedge clock) reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step; smp;
      chk("mid_no_rsp", rsp_valid, 0);
    end
    chk("mid_count_after", op_count, 0);

    // ALU_LATENCY=3 instance.
    step;
    l3_req_a0 = 4'd7; l3_req_b0 = 4'd12; l3_req_s0 = 3'd0;
    l3_req_valid = 2'b01; l3_rsp_ready = 1'b1;
    smp; chk("l3_accept", l3_req_ready, 2'b01);
    for (int k = 1; k <= 5; k++) begin
      step;
      l3_req_valid = '0;
      smp;
      if (k < 5) begin
        chk("l3_no_rsp", l3_rsp_valid, 0);
        chk("l3_alu_a", l3_alu_a, 7);
      end else begin
        chk("l3_rsp_valid", l3_rsp_valid, 1);
        chk("l3_rsp_data", l3_rsp_data, 8'h13);
      end
    end

    // Counter wrap over 257 back-to-back operations.
    do_reset;
    n = 0; t = 0; chk_next = 0; done = 0;
    step;
    req_a0 = 4'd1; req_b0 = 4'd1; req_valid = 2'b01; rsp_ready = 1'b1;
    while (!done && t < 1200) begin
      smp;
      if (chk_next) begin
        if (n == 256) chk("wrap_zero", op_count, 0);
        else begin chk("wrap_one", op_count, 1); done = 1; end
        chk_next = 0;
      end
      if (rsp_valid) begin
        n++;
        chk_next = (n >= 256);
      end
      if (!done) step;
      t++;
    end
    if (!done) chk("wrap_timeout", n, 257);

    // Random run against a transaction-level model.
    do_reset;
    m_pend = 0; m_lastg = 1; m_acc_t = 0; m_data = '0;
    m_a = '0; m_b = '0; m_s = '0; m_acc = '0; m_w = 0;
    for (int c = 0; c < 1500; c++) begin
      step;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || m_acc[i]) begin
          if (i == 0) {req_a0, req_b0, req_s0} = 11'($urandom);
          else        {req_a1, req_b1, req_s1} = 11'($urandom);
        end
        req_valid[i] = ($urandom_range(0, 3) != 0);
      end
      rsp_ready = 1'($urandom_range(0, 1));
      smp;
      m_er = '0;
      if (!m_pend && req_valid != 0) begin
        m_w  = (req_valid == 2'b11) ? !m_lastg : req_valid[1];
        m_er = m_w ? 2'b10 : 2'b01;
      end
      m_erv = m_pend && (c >= m_acc_t + 3);
      chk("rnd_ready", req_ready, m_er);
      chk("rnd_busy", busy, m_pend);
      chk("rnd_rsp_valid", rsp_valid, m_erv);
      chk("rnd_op_count", op_count, exp_cnt);
      chk("rnd_alu", {alu_a, alu_b, alu_s}, {m_a, m_b, m_s});
      if (m_erv) begin
        chk("rnd_rsp_id", rsp_id, m_w);
        chk("rnd_rsp_data", rsp_data, m_data);
      end
      m_acc = m_er;
      if (m_er != 0) begin
        m_pend = 1; m_acc_t = c; m_lastg = m_w;
        m_a = m_w ? req_a1 : req_a0;
        m_b = m_w ? req_b1 : req_b0;
        m_s = m_w ? req_s1 : req_s0;
        m_data = {4'b0, m_a} + {4'b0, m_b};
      end else if (m_erv && rsp_ready) begin
        m_pend = 0;
        exp_cnt++;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
